// File: rtl/icb_master_engine_if.sv
// icb_master_engine_if
//   Groups the client request/response port and the ICB cmd/rsp channels.
//   master : view taken by icb_master_engine (drives req_ready, icb_cmd_*,
//            icb_rsp_ready, rsp_*)
//   slave  : view taken by the client/bus environment (the other direction)
//   Parameters ADDR_W / DATA_W must match the engine instance.
interface icb_master_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    // client request
    logic              req_valid;
    logic              req_ready;
    logic              req_read;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    // ICB command
    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic              icb_cmd_read;
    logic [ADDR_W-1:0] icb_cmd_addr;
    logic [DATA_W-1:0] icb_cmd_wdata;
    logic [MASK_W-1:0] icb_cmd_wmask;
    // ICB response
    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic              icb_rsp_err;
    logic [DATA_W-1:0] icb_rsp_rdata;
    // client response
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_read;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        input  req_valid, req_read, req_addr, req_wdata, req_wmask,
        output req_ready,
        output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_cmd_ready,
        input  icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
        output icb_rsp_ready,
        output rsp_valid, rsp_read, rsp_err, rsp_rdata,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_read, req_addr, req_wdata, req_wmask,
        input  req_ready,
        input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        output icb_cmd_ready,
        output icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
        input  icb_rsp_ready,
        input  rsp_valid, rsp_read, rsp_err, rsp_rdata,
        output rsp_ready
    );
endinterface

// File: rtl/icb_master_engine.sv
// icb_master_engine
//   ICB initiator: registers client requests onto the ICB cmd channel,
//   tracks outstanding commands with an in-order read/write tag FIFO and
//   returns ICB responses to the client through a one-entry rsp register.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : icb_master_engine_if.master (client req/rsp + ICB cmd/rsp)
//   credits      : accepted but not yet retired requests (0..MAX_OUTST)
//   timeout_err  : sticky, set when an outstanding command waits TIMEOUT cycles
//   proto_err    : sticky, set on an ICB response with nothing outstanding
module icb_master_engine #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    icb_master_engine_if.master        bus,
    output logic [$clog2(MAX_OUTST):0] credits,
    output logic                       timeout_err,
    output logic                       proto_err
);
    localparam int MASK_W = DATA_W / 8;
    localparam int PW     = $clog2(MAX_OUTST);
    localparam int CW     = PW + 1;
    localparam int TW     = $clog2(TIMEOUT + 1);

    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_read_q,  cmd_read_d;
    logic [ADDR_W-1:0] cmd_addr_q,  cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [MASK_W-1:0] cmd_wmask_q, cmd_wmask_d;

    logic [MAX_OUTST-1:0] tag_q, tag_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        tag_cnt_q, tag_cnt_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_read_q,  rsp_read_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [CW-1:0] credits_q, credits_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          timeout_err_q, timeout_err_d;
    logic          proto_err_q, proto_err_d;

    logic req_ready, req_fire, cmd_fire;
    logic icb_rsp_ready, icb_rsp_fire, cli_rsp_fire;
    logic tag_empty, rsp_pop, tag_head;

    always_comb begin
        req_ready     = (credits_q < CW'(MAX_OUTST)) && (!cmd_valid_q || bus.icb_cmd_ready);
        req_fire      = bus.req_valid && req_ready;
        cmd_fire      = cmd_valid_q && bus.icb_cmd_ready;
        icb_rsp_ready = !rsp_valid_q || bus.rsp_ready;
        icb_rsp_fire  = bus.icb_rsp_valid && icb_rsp_ready;
        cli_rsp_fire  = rsp_valid_q && bus.rsp_ready;
        tag_empty     = (tag_cnt_q == '0);
        // a response arriving while the FIFO is empty cannot belong to the
        // command being pushed in the same cycle, so it is unsolicited
        rsp_pop       = icb_rsp_fire && !tag_empty;
        tag_head      = tag_q[rd_ptr_q];
    end

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_read_d  = cmd_read_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_wmask_d = cmd_wmask_q;
        if (req_fire) begin
            cmd_valid_d = 1'b1;
            cmd_read_d  = bus.req_read;
            cmd_addr_d  = bus.req_addr;
            cmd_wdata_d = bus.req_wdata;
            cmd_wmask_d = bus.req_wmask;
        end else if (cmd_fire) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_comb begin
        tag_d     = tag_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tag_cnt_d = tag_cnt_q;
        if (cmd_fire) begin
            tag_d[wr_ptr_q] = cmd_read_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (rsp_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({cmd_fire, rsp_pop})
            2'b10:   tag_cnt_d = tag_cnt_q + CW'(1);
            2'b01:   tag_cnt_d = tag_cnt_q - CW'(1);
            default: tag_cnt_d = tag_cnt_q;
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_read_d  = rsp_read_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        if (rsp_pop) begin
            rsp_valid_d = 1'b1;
            rsp_read_d  = tag_head;
            rsp_err_d   = bus.icb_rsp_err;
            rsp_rdata_d = tag_head ? bus.icb_rsp_rdata : '0;
        end else if (cli_rsp_fire) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_comb begin
        case ({req_fire, cli_rsp_fire})
            2'b10:   credits_d = credits_q + CW'(1);
            2'b01:   credits_d = credits_q - CW'(1);
            default: credits_d = credits_q;
        endcase
        tmr_d = tmr_q;
        if (tag_empty || icb_rsp_fire) begin
            tmr_d = '0;
        end else if (tmr_q != TW'(TIMEOUT)) begin
            tmr_d = tmr_q + TW'(1);
        end
        timeout_err_d = timeout_err_q || (tmr_d == TW'(TIMEOUT));
        proto_err_d   = proto_err_q || (icb_rsp_fire && tag_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_q   <= 1'b0;
            cmd_read_q    <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= '0;
            cmd_wmask_q   <= '0;
            tag_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_cnt_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_read_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            credits_q     <= '0;
            tmr_q         <= '0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            cmd_valid_q   <= cmd_valid_d;
            cmd_read_q    <= cmd_read_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            cmd_wmask_q   <= cmd_wmask_d;
            tag_q         <= tag_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_cnt_q     <= tag_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_read_q    <= rsp_read_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
            credits_q     <= credits_d;
            tmr_q         <= tmr_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.icb_cmd_valid = cmd_valid_q;
    assign bus.icb_cmd_read  = cmd_read_q;
    assign bus.icb_cmd_addr  = cmd_addr_q;
    assign bus.icb_cmd_wdata = cmd_wdata_q;
    assign bus.icb_cmd_wmask = cmd_wmask_q;
    assign bus.icb_rsp_ready = icb_rsp_ready;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_read      = rsp_read_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign credits           = credits_q;
    assign timeout_err       = timeout_err_q;
    assign proto_err         = proto_err_q;
endmodule

// File: tb/tb_icb_master_engine.sv
// tb_icb_master_engine
//   Directed bench for icb_master_engine (MAX_OUTST=4, TIMEOUT=16).
//   Inputs are driven on the falling edge; outputs are sampled on the
//   falling edge (registered) or 1 time unit after driving (combinational).
module tb_icb_master_engine;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] credits;
    logic       timeout_err;
    logic       proto_err;

    always #5 clk = ~clk;

    icb_master_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    icb_master_engine #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .credits     (credits),
        .timeout_err (timeout_err),
        .proto_err   (proto_err)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        berr;
        logic [31:0] brdata;
        logic        exp_read;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.req_valid     = 1'b0;
        bus.req_read      = 1'b0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.req_wmask     = '0;
        bus.icb_cmd_ready = 1'b1;
        bus.icb_rsp_valid = 1'b0;
        bus.icb_rsp_err   = 1'b0;
        bus.icb_rsp_rdata = '0;
        bus.rsp_ready     = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns on the falling edge right after the accepting clock edge.
    task automatic send_req(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wmask, output logic ok);
        bus.req_valid = 1'b1;
        bus.req_read  = rd;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.req_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
    endtask

    logic        ok;
    int          acc;
    logic        exp_rd  [3];
    logic        exp_er  [3];
    logic [31:0] exp_dat [3];
    logic [31:0] rsp_dat [3];
    logic        rsp_er  [3];

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{rd:1'b0, addr:32'h10,  wdata:32'hDEADBEEF, wmask:4'hF, berr:1'b0, brdata:32'h0,
                    exp_read:1'b0, exp_err:1'b0, exp_rdata:32'h0};
        vecs[1] = '{rd:1'b1, addr:32'h10,  wdata:32'h0,        wmask:4'hF, berr:1'b0, brdata:32'hDEADBEEF,
                    exp_read:1'b1, exp_err:1'b0, exp_rdata:32'hDEADBEEF};
        vecs[2] = '{rd:1'b0, addr:32'h80,  wdata:32'h01020304, wmask:4'h6, berr:1'b1, brdata:32'h12345678,
                    exp_read:1'b0, exp_err:1'b1, exp_rdata:32'h0};
        vecs[3] = '{rd:1'b1, addr:32'hFFC, wdata:32'h0,        wmask:4'h1, berr:1'b1, brdata:32'hCAFEF00D,
                    exp_read:1'b1, exp_err:1'b1, exp_rdata:32'hCAFEF00D};

        set_idle();
        do_reset();
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_cmd_valid", bus.icb_cmd_valid, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_credits", credits, 0);
        chk("rst_errs", {timeout_err, proto_err}, 0);

        // single transactions from the table, slave answers one cycle after cmd
        for (int v = 0; v < 4; v++) begin
            send_req(vecs[v].rd, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, ok);
            chk("vec_accept", ok, 1);
            chk("vec_cmd_valid", bus.icb_cmd_valid, 1);
            chk("vec_cmd_read", bus.icb_cmd_read, vecs[v].rd);
            chk("vec_cmd_addr", bus.icb_cmd_addr, vecs[v].addr);
            chk("vec_cmd_wdata", bus.icb_cmd_wdata, vecs[v].wdata);
            chk("vec_cmd_wmask", bus.icb_cmd_wmask, vecs[v].wmask);
            @(negedge clk);
            chk("vec_cmd_dropped", bus.icb_cmd_valid, 0);
            bus.icb_rsp_valid = 1'b1;
            bus.icb_rsp_err   = vecs[v].berr;
            bus.icb_rsp_rdata = vecs[v].brdata;
            #1;
            chk("vec_icb_rsp_ready", bus.icb_rsp_ready, 1);
            @(negedge clk);
            bus.icb_rsp_valid = 1'b0;
            chk("vec_rsp_valid", bus.rsp_valid, 1);
            chk("vec_rsp_read", bus.rsp_read, vecs[v].exp_read);
            chk("vec_rsp_err", bus.rsp_err, vecs[v].exp_err);
            chk("vec_rsp_rdata", bus.rsp_rdata, vecs[v].exp_rdata);
            @(negedge clk);
            chk("vec_rsp_retired", bus.rsp_valid, 0);
            chk("vec_credits", credits, 0);
        end

        // credit limit, back-to-back acceptance
        do_reset();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_read  = 1'b0;
        bus.req_addr  = 32'h40;
        bus.req_wdata = 32'h1;
        bus.req_wmask = 4'hF;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.req_valid && bus.req_ready) acc++;
            if (i == 3) chk("cred_b2b_accepts", acc, 4);
            @(negedge clk);
        end
        #1;
        chk("cred_req_ready_low", bus.req_ready, 0);
        chk("cred_credits_full", credits, 4);
        chk("cred_accepts", acc, 4);
        bus.icb_rsp_valid = 1'b1;
        @(negedge clk);
        bus.icb_rsp_valid = 1'b0;
        chk("cred_rsp_valid", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
        #1;
        chk("cred_still_full", bus.req_ready, 0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("cred_after_pulse", credits, 3);
        chk("cred_rsp_retired", bus.rsp_valid, 0);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.req_valid && bus.req_ready) acc++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("cred_one_more", acc, 5);
        chk("cred_refilled", credits, 4);

        // cmd backpressure
        do_reset();
        bus.icb_cmd_ready = 1'b0;
        send_req(1'b0, 32'h24, 32'h55AA33CC, 4'h3, ok);
        chk("bp_accept", ok, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_valid", bus.icb_cmd_valid, 1);
            chk("bp_cmd_stable", {bus.icb_cmd_addr[15:0], bus.icb_cmd_wdata, bus.icb_cmd_wmask},
                {16'h0024, 32'h55AA33CC, 4'h3});
            #1;
            chk("bp_req_ready", bus.req_ready, 0);
            @(negedge clk);
        end
        bus.icb_cmd_ready = 1'b1;
        @(negedge clk);
        chk("bp_single_fire", bus.icb_cmd_valid, 0);
        bus.icb_rsp_valid = 1'b1;
        @(negedge clk);
        bus.icb_rsp_valid = 1'b0;
        chk("bp_rsp", {bus.rsp_valid, bus.rsp_read, bus.rsp_err}, 3'b100);
        @(negedge clk);
        chk("bp_done", {bus.rsp_valid, credits}, 4'b0000);
        bus.icb_rsp_valid = 1'b1;
        @(negedge clk);
        bus.icb_rsp_valid = 1'b0;
        chk("bp_no_extra_tag", proto_err, 1);

        // mixed R,W,R with error on the second response
        do_reset();
        exp_rd  = '{1'b1, 1'b0, 1'b1};
        exp_er  = '{1'b0, 1'b1, 1'b0};
        exp_dat = '{32'h11111111, 32'h0, 32'h33333333};
        rsp_dat = '{32'h11111111, 32'h22222222, 32'h33333333};
        rsp_er  = '{1'b0, 1'b1, 1'b0};
        bus.req_valid = 1'b1;
        bus.req_read  = 1'b1;
        bus.req_addr  = 32'h100;
        #1;
        chk("mix_rdy0", bus.req_ready, 1);
        @(negedge clk);
        bus.req_read  = 1'b0;
        bus.req_addr  = 32'h104;
        bus.req_wdata = 32'hA5A5A5A5;
        #1;
        chk("mix_rdy1", bus.req_ready, 1);
        @(negedge clk);
        bus.req_read = 1'b1;
        bus.req_addr = 32'h108;
        #1;
        chk("mix_rdy2", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bus.icb_rsp_valid = 1'b1;
            bus.icb_rsp_err   = rsp_er[k];
            bus.icb_rsp_rdata = rsp_dat[k];
            @(negedge clk);
            bus.icb_rsp_valid = 1'b0;
            chk("mix_rsp_valid", bus.rsp_valid, 1);
            chk("mix_rsp_read", bus.rsp_read, exp_rd[k]);
            chk("mix_rsp_err", bus.rsp_err, exp_er[k]);
            chk("mix_rsp_rdata", bus.rsp_rdata, exp_dat[k]);
        end
        @(negedge clk);
        chk("mix_done", {bus.rsp_valid, credits}, 4'b0000);

        // timeout
        do_reset();
        repeat (30) @(negedge clk);
        chk("idle_no_timeout", timeout_err, 0);
        send_req(1'b1, 32'h200, 32'h0, 4'hF, ok);
        chk("to_accept", ok, 1);
        repeat (16) @(negedge clk);
        chk("to_not_yet", timeout_err, 0);
        @(negedge clk);
        chk("to_set", timeout_err, 1);
        repeat (3) @(negedge clk);
        bus.icb_rsp_valid = 1'b1;
        bus.icb_rsp_rdata = 32'h0BADF00D;
        @(negedge clk);
        bus.icb_rsp_valid = 1'b0;
        chk("to_late_rsp", {bus.rsp_valid, bus.rsp_read, bus.rsp_err}, 3'b110);
        chk("to_late_rdata", bus.rsp_rdata, 32'h0BADF00D);
        chk("to_sticky", timeout_err, 1);
        @(negedge clk);
        chk("to_done", {bus.rsp_valid, credits, timeout_err}, 5'b00001);

        // unsolicited response, then reset with 3 outstanding
        bus.icb_rsp_valid = 1'b1;
        #1;
        chk("uns_icb_rsp_ready", bus.icb_rsp_ready, 1);
        @(negedge clk);
        bus.icb_rsp_valid = 1'b0;
        chk("uns_proto_err", proto_err, 1);
        chk("uns_no_rsp", bus.rsp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            send_req(1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'hF, ok);
            chk("rst_mid_accept", ok, 1);
        end
        chk("rst_mid_credits", credits, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_clear", {credits, proto_err, timeout_err}, 5'b00000);
        chk("rst_mid_req_ready", bus.req_ready, 1);
        chk("rst_mid_cmd_valid", bus.icb_cmd_valid, 0);
        chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
        repeat (3) @(negedge clk);
        chk("rst_no_replay", bus.icb_cmd_valid, 0);
        bus.icb_rsp_valid = 1'b1;
        @(negedge clk);
        bus.icb_rsp_valid = 1'b0;
        chk("rst_fifo_cleared", {proto_err, bus.rsp_valid}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/icb_master_engine.md
Name: icb_master_engine

Overview:
- ICB initiator that sits between a simple request/response client port and the ICB bus. It drives the cmd channel, consumes the rsp channel and returns responses to the client in order.
- Supports up to MAX_OUTST requests in flight, tracked by credits and an in-order read/write tag FIFO.
- Flags response timeouts and unsolicited responses with sticky error bits.
- Intended as the RTL master counterpart to the team's ICB slave models and peripherals.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- MAX_OUTST, 4, maximum accepted-but-not-retired requests (power of two, >=2).
- TIMEOUT, 255, cycles without an rsp handshake while ICB commands are outstanding before timeout_err sets.

Ports:
- clk  in  1  clock; single clock domain, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  client request accepted when valid&&ready.
- req_read  in  1  1=read, 0=write.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wmask  in  DATA_W/8  byte enables.
- icb_cmd_valid  out  1  ICB command valid.
- icb_cmd_ready  in  1  ICB command ready.
- icb_cmd_read  out  1  ICB read flag.
- icb_cmd_addr  out  ADDR_W  ICB address.
- icb_cmd_wdata  out  DATA_W  ICB write data.
- icb_cmd_wmask  out  DATA_W/8  ICB byte mask.
- icb_rsp_valid  in  1  ICB response valid.
- icb_rsp_ready  out  1  ICB response ready.
- icb_rsp_err  in  1  ICB response error.
- icb_rsp_rdata  in  DATA_W  ICB read data.
- rsp_valid  out  1  client response valid.
- rsp_ready  in  1  client response ready.
- rsp_read  out  1  response belongs to a read.
- rsp_err  out  1  bus error for this response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- credits  out  $clog2(MAX_OUTST)+1  accepted, not yet retired requests.
- timeout_err  out  1  sticky timeout flag.
- proto_err  out  1  sticky unsolicited-response flag.

Behaviour:
- Reset: every output register clears to 0. This covers icb_cmd_*, icb_rsp_ready source state, rsp_*, credits, timeout_err, proto_err, tag FIFO pointers/count and the timeout counter.
- Cmd stage (one register):
  - req_ready = (credits < MAX_OUTST) && (!icb_cmd_valid || icb_cmd_ready). It is combinational and not gated by req_valid.
  - On req fire the cmd register loads the request and icb_cmd_valid=1 next cycle. Latency is 1 cycle from req fire to icb_cmd_valid.
  - While icb_cmd_valid && !icb_cmd_ready, all icb_cmd_* hold stable.
  - On cmd fire without a new req, icb_cmd_valid drops next cycle.
  - Back-to-back fire sustains 1 command/cycle.
- Tag FIFO (depth MAX_OUTST):
  - Pushes icb_cmd_read on cmd fire; pops on icb_rsp fire.
  - Simultaneous push and pop in one cycle leaves count unchanged. Pointers wrap modulo MAX_OUTST.
  - The credit bound guarantees the FIFO never overflows.
- Rsp stage (one-entry register):
  - icb_rsp_ready = !rsp_valid || rsp_ready.
  - On icb_rsp fire with a non-empty tag FIFO: rsp_valid=1 next cycle, rsp_read=FIFO head, rsp_err=icb_rsp_err. rsp_rdata=icb_rsp_rdata for reads, 0 for writes.
  - Held stable until rsp_ready. Latency is 1 cycle from ICB rsp to client rsp.
- Credits:
  - +1 on req fire; -1 on client rsp fire (rsp_valid&&rsp_ready); unchanged when both occur in the same cycle.
  - Range 0..MAX_OUTST.
- Unsolicited response:
  - icb_rsp fire while the tag FIFO is empty is dropped (no client rsp) and proto_err sets.
  - proto_err is sticky until rst.
- Timeout:
  - The counter clears when the tag FIFO is empty or on icb_rsp fire; otherwise it increments, saturating at TIMEOUT.
  - When it reaches TIMEOUT, timeout_err=1 (sticky until rst).
  - No transaction is aborted; a late response is still delivered normally.
- Reset mid-operation: all in-flight state is discarded and nothing is replayed. The first cycle after rst deasserts shows req_ready=1 and icb_cmd_valid=0.

Test Plan:
- Single write, then read: write addr 0x10, wdata 0xDEADBEEF, wmask 0xF; slave responds one cycle later. Required: icb_cmd_* match the request; rsp_read=0, rsp_rdata=0. The read of 0x10 returns rsp_read=1, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Credit limit: hold rsp_ready=0 and issue 6 requests with MAX_OUTST=4. Required: req_ready=0 after 4 accepts and credits=4. After 1 rsp_ready pulse, exactly one more request is accepted.
- Cmd backpressure: icb_cmd_ready=0 for 5 cycles during a write to 0x24. Required: icb_cmd_addr/wdata/wmask stable for all 5 cycles, req_ready=0, single cmd fire once ready=1.
- Mixed ordering with error: issue R,W,R; slave returns err=1 on the second response. Required: client sees rsp_read=1,0,1 in order, with rsp_err only on the second.
- Timeout with TIMEOUT=16: issue a read and withhold the response. Required: timeout_err=1 exactly 16 cycles after cmd fire. A response at cycle 20 is still delivered, and timeout_err stays 1.
- Unsolicited response and reset: icb_rsp_valid=1 with nothing outstanding sets proto_err with no rsp_valid. Asserting rst with 3 outstanding clears credits, proto_err and timeout_err to 0.
